// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: A = in-order writeback, B = buffered multi-cycle results.
// One registered write per cycle (1-cycle from grant); A stalls via a_ready, B via FIFO-full b_ready.
module wb_port_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          a_valid,
   output logic                          a_ready,
   input  logic [4:0]                    a_num,
   input  logic [31:0]                   a_data,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [4:0]                    b_num,
   input  logic [31:0]                   b_data,
   output logic                          wb_to_reg_en,
   output logic [4:0]                    wb_to_reg_num,
   output logic [31:0]                   wb_to_reg_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic {NORMAL, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [SW-1:0]  starve_cnt;
   logic           push, grant_a, grant_b, grant, force_b, fifo_nonempty;
   logic [CW-1:0]  cnt_nxt;
   logic [36:0]    head;
   logic [4:0]     g_num;
   logic [31:0]    g_data;

   assign fifo_nonempty = (fifo_count != '0);
   assign b_ready       = (fifo_count != CNT_FULL);
   assign push          = b_valid && b_ready;
   assign force_b       = (starve_cnt == STARVE_MAX) && fifo_nonempty;
   assign busy          = (state == DRAIN) || fifo_nonempty;

   wb_fifo #(
      .WIDTH (37),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push),
      .push_dat ({b_num, b_data}),
      .pop_vld  (grant_b),
      .pop_dat  (head),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= NORMAL;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      a_ready   = 1'b0;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      cnt_nxt   = fifo_count;
      case (state)
         NORMAL: begin
            a_ready = !force_b;
            if (a_valid && !force_b) grant_a = 1'b1;
            else if (fifo_nonempty)  grant_b = 1'b1;
         end
         DRAIN: begin
            grant_b = fifo_nonempty;
         end
         default: ;
      endcase
      cnt_nxt = fifo_count + CW'(push) - CW'(grant_b);
      if (state == NORMAL && cnt_nxt == CNT_FULL) state_nxt = DRAIN;
      if (state == DRAIN && cnt_nxt == '0)        state_nxt = NORMAL;
   end

   // Age of the current FIFO head; any pop restarts the count for the next head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           starve_cnt <= '0;
      else if (!fifo_nonempty || grant_b) starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)  starve_cnt <= starve_cnt + 1'b1;
   end

   assign grant  = grant_a || grant_b;
   assign g_num  = grant_a ? a_num  : head[36:32];
   assign g_data = grant_a ? a_data : head[31:0];

   // x0 results are consumed like any other grant but never raise the enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_to_reg_en   <= 1'b0;
         wb_to_reg_num  <= '0;
         wb_to_reg_data <= '0;
      end else begin
         wb_to_reg_en <= grant && (g_num != 5'd0);
         if (grant) begin
            wb_to_reg_num  <= g_num;
            wb_to_reg_data <= g_data;
         end
      end
   end

endmodule

// Generic circular FIFO, no bypass; the caller guarantees no push when full / pop when empty.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_vld,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop_vld,
   output logic [WIDTH-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;

   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + 1'b1;
         if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with FIFO_DEPTH=4, STARVE_LIMIT=8.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid, a_ready;
   logic [4:0]  a_num;
   logic [31:0] a_data;
   logic        b_valid, b_ready;
   logic [4:0]  b_num;
   logic [31:0] b_data;
   logic        wb_to_reg_en;
   logic [4:0]  wb_to_reg_num;
   logic [31:0] wb_to_reg_data;
   logic [2:0]  fifo_count;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter #(
      .FIFO_DEPTH   (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .a_valid        (a_valid),
      .a_ready        (a_ready),
      .a_num          (a_num),
      .a_data         (a_data),
      .b_valid        (b_valid),
      .b_ready        (b_ready),
      .b_num          (b_num),
      .b_data         (b_data),
      .wb_to_reg_en   (wb_to_reg_en),
      .wb_to_reg_num  (wb_to_reg_num),
      .wb_to_reg_data (wb_to_reg_data),
      .fifo_count     (fifo_count),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] num, input logic [31:0] data);
      chk({tag, "_en"},   wb_to_reg_en,   en);
      chk({tag, "_num"},  wb_to_reg_num,  num);
      chk({tag, "_data"}, wb_to_reg_data, data);
   endtask

   initial begin
      rst = 1'b0;
      a_valid = 0; a_num = 0; a_data = 0;
      b_valid = 0; b_num = 0; b_data = 0;

      // Reset state
      #3;
      chk_wr("rst", 0, 5'd0, 32'h0);
      chk("rst_count", fifo_count, 0);
      chk("rst_b_ready", b_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_a_ready", a_ready, 1);
      cyc(); cyc();
      #2 rst = 1'b1;
      cyc();

      // 1. A only
      a_valid = 1; a_num = 5'd5; a_data = 32'h1234;
      #1 chk("t1_a_ready", a_ready, 1);
      cyc();
      chk_wr("t1_wr", 1, 5'd5, 32'h1234);
      a_valid = 0;
      cyc();
      chk_wr("t1_idle", 0, 5'd5, 32'h1234);

      // 2. x0 from A, then x0 from B
      a_valid = 1; a_num = 5'd0; a_data = 32'hDEAD;
      #1 chk("t2_a_ready", a_ready, 1);
      cyc();
      chk_wr("t2_a_x0", 0, 5'd0, 32'hDEAD);
      a_valid = 0;
      b_valid = 1; b_num = 5'd0; b_data = 32'h55;
      #1 chk("t2_b_ready", b_ready, 1);
      cyc();
      b_valid = 0;
      chk("t2_count1", fifo_count, 1);
      chk("t2_busy", busy, 1);
      cyc();
      chk_wr("t2_b_x0", 0, 5'd0, 32'h55);
      chk("t2_count0", fifo_count, 0);

      // 3. Starvation: one B waits exactly 8 cycles behind a continuous A stream
      a_valid = 1; a_num = 5'd3; a_data = 32'h33;
      b_valid = 1; b_num = 5'd7; b_data = 32'hAA;
      cyc();
      b_valid = 0;
      chk_wr("t3_a0", 1, 5'd3, 32'h33);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3_wait%0d_a_ready", i), a_ready, 1);
         cyc();
         chk($sformatf("t3_wait%0d_num", i), wb_to_reg_num, 5'd3);
      end
      chk("t3_force_a_ready", a_ready, 0);
      cyc();
      chk_wr("t3_b", 1, 5'd7, 32'hAA);
      chk("t3_count", fifo_count, 0);
      chk("t3_a_ready_back", a_ready, 1);

      // 4. Fill the FIFO behind A, then drain in order
      for (int i = 0; i < 4; i++) begin
         b_valid = 1; b_num = 5'(8 + i); b_data = 32'hB0 + i;
         #1 chk($sformatf("t4_push%0d_b_ready", i), b_ready, 1);
         cyc();
         chk($sformatf("t4_push%0d_num", i), wb_to_reg_num, 5'd3);
      end
      b_num = 5'd31; b_data = 32'hFFFF;
      #1;
      chk("t4_full_b_ready", b_ready, 0);
      chk("t4_full_count", fifo_count, 4);
      chk("t4_full_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_drain%0d_a_ready", i), a_ready, 0);
         cyc();
         b_valid = 0;
         chk_wr($sformatf("t4_drain%0d", i), 1, 5'(8 + i), 32'hB0 + i);
      end
      chk("t4_count0", fifo_count, 0);
      chk("t4_busy0", busy, 0);
      chk("t4_a_ready", a_ready, 1);
      cyc();
      chk_wr("t4_a_resume", 1, 5'd3, 32'h33);

      // 5. Simultaneous A and B with empty FIFO
      a_valid = 1; a_num = 5'd10; a_data = 32'hA5;
      b_valid = 1; b_num = 5'd11; b_data = 32'hB5;
      cyc();
      a_valid = 0; b_valid = 0;
      chk_wr("t5_a", 1, 5'd10, 32'hA5);
      chk("t5_count", fifo_count, 1);
      cyc();
      chk_wr("t5_b", 1, 5'd11, 32'hB5);
      chk("t5_count0", fifo_count, 0);

      // 6. Async reset with three buffered entries
      a_valid = 1; a_num = 5'd3; a_data = 32'h33;
      for (int i = 0; i < 3; i++) begin
         b_valid = 1; b_num = 5'(20 + i); b_data = 32'hC0 + i;
         cyc();
      end
      b_valid = 0;
      chk("t6_count3", fifo_count, 3);
      #1 rst = 1'b0;
      #1;
      chk_wr("t6_rst", 0, 5'd0, 32'h0);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_busy", busy, 0);
      a_valid = 0;
      cyc();
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("t6_post%0d_en", i), wb_to_reg_en, 0);
         chk($sformatf("t6_post%0d_count", i), fifo_count, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
